cipher_uut_driver: RTL

CIPHER_UUT_DRIVER -- requirements
Module: cipher_uut_driver

---
 rtl/cipher_uut_driver_pkg.sv | 22 ++
 rtl/cipher_uut_driver_if.sv | 40 ++++
 rtl/uut_cycle_counter.sv | 38 +++
 rtl/cipher_uut_driver.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cipher_uut_driver_pkg.sv
// Shared types and default widths for the cipher UUT driver slice.
package cipher_uut_driver_pkg;

  localparam int unsigned DEF_BLOCK_W = 64;
  localparam int unsigned DEF_KEY_W   = 80;
  localparam int unsigned DEF_CNT_W   = 32;
  localparam int unsigned RUNS_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UUT_RST,
    ST_RUN,
    ST_CAPTURE,
    ST_DONE
  } state_e;

  // A request for zero runs still performs one run.
  function automatic logic [RUNS_W-1:0] runs_norm(input logic [RUNS_W-1:0] r);
    return (r == '0) ? RUNS_W'(1) : r;
  endfunction

endpackage

// File: rtl/cipher_uut_driver_if.sv
// Host-side and UUT-side signal bundle of the cipher UUT driver.
interface cipher_uut_driver_if #(
  parameter int unsigned BLOCK_W = cipher_uut_driver_pkg::DEF_BLOCK_W,
  parameter int unsigned KEY_W   = cipher_uut_driver_pkg::DEF_KEY_W,
  parameter int unsigned CNT_W   = cipher_uut_driver_pkg::DEF_CNT_W
) ();

  logic               start_i;
  logic               encdec_i;
  logic               chain_i;
  logic [15:0]        runs_i;
  logic [BLOCK_W-1:0] block_i;
  logic [KEY_W-1:0]   key_i;
  logic               busy_o;
  logic               done_o;
  logic               timeout_o;
  logic [BLOCK_W-1:0] block_o;
  logic [CNT_W-1:0]   cycles_o;
  logic               rst_uut_o;
  logic               encdec_uut_o;
  logic [BLOCK_W-1:0] block_uut_o;
  logic [KEY_W-1:0]   key_uut_o;
  logic [BLOCK_W-1:0] block_uut_i;
  logic               end_uut_i;

  modport master (
    output start_i, encdec_i, chain_i, runs_i, block_i, key_i,
    input  busy_o, done_o, timeout_o, block_o, cycles_o,
    input  rst_uut_o, encdec_uut_o, block_uut_o, key_uut_o,
    output block_uut_i, end_uut_i
  );

  modport slave (
    input  start_i, encdec_i, chain_i, runs_i, block_i, key_i,
    output busy_o, done_o, timeout_o, block_o, cycles_o,
    output rst_uut_o, encdec_uut_o, block_uut_o, key_uut_o,
    input  block_uut_i, end_uut_i
  );

endinterface

// File: rtl/uut_cycle_counter.sv
// Accumulated RUN-cycle counter (saturating) plus per-run timeout detection.
module uut_cycle_counter #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_total,
  input  logic             clear_run,
  input  logic             en,
  output logic [CNT_W-1:0] total,
  output logic             timeout_c
);

  localparam int unsigned RUN_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [RUN_W-1:0] run_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total     <= '0;
      run_cnt_q <= '0;
    end else begin
      if (clear_total)
        total <= '0;
      else if (en && (total != '1))
        total <= total + CNT_W'(1);
      if (clear_run)
        run_cnt_q <= '0;
      else if (en && (run_cnt_q != RUN_W'(TIMEOUT_CYCLES)))
        run_cnt_q <= run_cnt_q + RUN_W'(1);
    end
  end

  // Fires in the RUN cycle that would complete the allowed budget.
  assign timeout_c = en && (run_cnt_q == RUN_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cipher_uut_driver.sv
// Drives a cipher UUT through repeated reset/run/capture sequences and times each run.
module cipher_uut_driver
  import cipher_uut_driver_pkg::*;
#(
  parameter int unsigned BLOCK_W        = DEF_BLOCK_W,
  parameter int unsigned KEY_W          = DEF_KEY_W,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  cipher_uut_driver_if.slave bus
);

  localparam int unsigned RST_CNT_W = $clog2(RST_CYCLES + 1);

  state_e                state_q, state_d;
  logic [BLOCK_W-1:0]    blk_lat_q, blk_lat_d;
  logic [BLOCK_W-1:0]    block_o_q, block_o_d;
  logic [BLOCK_W-1:0]    block_uut_q, block_uut_d;
  logic [KEY_W-1:0]      key_q, key_d;
  logic                  encdec_q, encdec_d;
  logic                  chain_q, chain_d;
  logic                  timeout_q, timeout_d;
  logic [RUNS_W-1:0]     runs_left_q, runs_left_d;
  logic [RST_CNT_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic                  busy_q, done_q, rst_uut_q;
  logic                  clear_total_c, clear_run_c, run_en_c, timeout_c;
  logic [CNT_W-1:0]      cycles;

  uut_cycle_counter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clear_total (clear_total_c),
    .clear_run   (clear_run_c),
    .en          (run_en_c),
    .total       (cycles),
    .timeout_c   (timeout_c)
  );

  assign clear_total_c = (state_q == ST_IDLE) && bus.start_i;
  assign clear_run_c   = (state_q == ST_UUT_RST);
  assign run_en_c      = (state_q == ST_RUN);

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    blk_lat_d   = blk_lat_q;
    block_o_d   = block_o_q;
    block_uut_d = block_uut_q;
    key_d       = key_q;
    encdec_d    = encdec_q;
    chain_d     = chain_q;
    timeout_d   = timeout_q;
    runs_left_d = runs_left_q;
    rst_cnt_d   = rst_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          blk_lat_d   = bus.block_i;
          block_uut_d = bus.block_i;
          key_d       = bus.key_i;
          encdec_d    = bus.encdec_i;
          chain_d     = bus.chain_i;
          runs_left_d = runs_norm(bus.runs_i);
          timeout_d   = 1'b0;
          rst_cnt_d   = '0;
          state_d     = ST_UUT_RST;
        end
      end
      ST_UUT_RST: begin
        if (rst_cnt_q == RST_CNT_W'(RST_CYCLES - 1))
          state_d = ST_RUN;
        else
          rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
      end
      ST_RUN: begin
        if (bus.end_uut_i) begin
          state_d = ST_CAPTURE;
        end else if (timeout_c) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_CAPTURE: begin
        block_o_d   = bus.block_uut_i;
        runs_left_d = runs_left_q - RUNS_W'(1);
        if (runs_left_q == RUNS_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          block_uut_d = chain_q ? bus.block_uut_i : blk_lat_q;
          rst_cnt_d   = '0;
          state_d     = ST_UUT_RST;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      blk_lat_q   <= '0;
      block_o_q   <= '0;
      block_uut_q <= '0;
      key_q       <= '0;
      encdec_q    <= 1'b0;
      chain_q     <= 1'b0;
      timeout_q   <= 1'b0;
      runs_left_q <= '0;
      rst_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rst_uut_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      blk_lat_q   <= blk_lat_d;
      block_o_q   <= block_o_d;
      block_uut_q <= block_uut_d;
      key_q       <= key_d;
      encdec_q    <= encdec_d;
      chain_q     <= chain_d;
      timeout_q   <= timeout_d;
      runs_left_q <= runs_left_d;
      rst_cnt_q   <= rst_cnt_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      rst_uut_q   <= (state_d != ST_RUN) && (state_d != ST_CAPTURE);
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.timeout_o    = timeout_q;
  assign bus.block_o      = block_o_q;
  assign bus.cycles_o     = cycles;
  assign bus.rst_uut_o    = rst_uut_q;
  assign bus.encdec_uut_o = encdec_q;
  assign bus.block_uut_o  = block_uut_q;
  assign bus.key_uut_o    = key_q;

endmodule
